// File: rtl/ex_stage_mdu_if.sv
// Decode-to-execute and execute-to-memory handshake bundle for ex_stage_mdu.
// master = surrounding pipeline (drives in_*, out_ready); slave = the execute stage.
interface ex_stage_mdu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_alu_op;
  logic             in_src_a_sel;
  logic             in_src_b_sel;
  logic             in_br_en;
  logic [2:0]       in_br_op;
  logic             in_md_en;
  logic [2:0]       in_md_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [XLEN-1:0]  out_rs2;
  logic [XLEN-1:0]  out_imm;
  logic             out_branch_taken;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_alu_op, in_src_a_sel, in_src_b_sel, in_br_en, in_br_op,
           in_md_en, in_md_op, in_rs1, in_rs2, in_pc, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_rs2, out_imm, out_branch_taken, out_tag
  );

  modport slave (
    input  in_valid, in_alu_op, in_src_a_sel, in_src_b_sel, in_br_en, in_br_op,
           in_md_en, in_md_op, in_rs1, in_rs2, in_pc, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_rs2, out_imm, out_branch_taken, out_tag
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// Execute stage: single-cycle ALU/branch plus, when EX_MDU_EN is defined, an
// iterative radix-2 multiply/divide unit with fixed XLEN+1 cycle latency.
module ex_stage_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  ex_stage_mdu_if.slave bus,
  output logic          busy
);
  localparam int SHW = $clog2(XLEN);
  typedef logic [XLEN-1:0] word_t;

  word_t            src_a, src_b, alu_res;
  logic             br_cond, br_taken;
  logic             out_free, accept, alu_accept, md_load, mdu_idle;
  word_t            md_res, md_rs2, md_imm;
  logic [TAG_W-1:0] md_tag;
  logic             md_br;

  logic             out_valid_q, out_br_q;
  word_t            out_result_q, out_rs2_q, out_imm_q;
  logic [TAG_W-1:0] out_tag_q;

  always_comb begin
    src_a = bus.in_src_a_sel ? bus.in_pc : bus.in_rs1;
    src_b = bus.in_src_b_sel ? bus.in_imm : bus.in_rs2;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_res = '0;
    case (bus.in_alu_op)
      4'd0:  alu_res = src_a + src_b;
      4'd1:  alu_res = src_a - src_b;
      4'd2:  alu_res = src_a << src_b[SHW-1:0];
      4'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd4:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'd5:  alu_res = src_a ^ src_b;
      4'd6:  alu_res = src_a >> src_b[SHW-1:0];
      4'd7:  alu_res = $signed(src_a) >>> src_b[SHW-1:0];
      4'd8:  alu_res = src_a | src_b;
      4'd9:  alu_res = src_a & src_b;
      4'd10: alu_res = src_b;
      default: alu_res = '0;
    endcase

    // Branches always compare the raw register operands, never the muxed sources.
    br_cond = 1'b0;
    case (bus.in_br_op)
      3'b000: br_cond = bus.in_rs1 == bus.in_rs2;
      3'b001: br_cond = bus.in_rs1 != bus.in_rs2;
      3'b100: br_cond = $signed(bus.in_rs1) <  $signed(bus.in_rs2);
      3'b101: br_cond = $signed(bus.in_rs1) >= $signed(bus.in_rs2);
      3'b110: br_cond = bus.in_rs1 <  bus.in_rs2;
      3'b111: br_cond = bus.in_rs1 >= bus.in_rs2;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken     = bus.in_br_en && br_cond;
  assign out_free     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !flush && mdu_idle && out_free;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef EX_MDU_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q;
  logic [SHW-1:0]    cnt_q;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc_q;          // mul: {hi, multiplier}; div: {remainder, quotient}
  word_t             opnd_q, dvd_q, rs2_q, imm_q;
  logic [TAG_W-1:0]  tag_q;
  logic              br_q, a_neg_q, b_neg_q, b_zero_q;

  logic              a_signed, b_signed, a_neg, b_neg;
  word_t             a_mag, b_mag, quo, rem;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] acc_step, prod;

  always_comb begin
    if (bus.in_md_op[2]) begin
      a_signed = !bus.in_md_op[0];
      b_signed = !bus.in_md_op[0];
    end else begin
      a_signed = (bus.in_md_op[1:0] == 2'b01) || (bus.in_md_op[1:0] == 2'b10);
      b_signed = (bus.in_md_op[1:0] == 2'b01);
    end
    a_neg = a_signed && bus.in_rs1[XLEN-1];
    b_neg = b_signed && bus.in_rs2[XLEN-1];
    a_mag = a_neg ? -bus.in_rs1 : bus.in_rs1;
    b_mag = b_neg ? -bus.in_rs2 : bus.in_rs2;

    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    if (!op_q[2])
      acc_step = {sum, acc_q[XLEN-1:1]};
    else if (!diff[XLEN])
      acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    // Unit works on magnitudes; signs are restored here in DONE.
    prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo  = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                md_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        md_res = b_zero_q ? '1 : quo;
      default:               md_res = b_zero_q ? dvd_q : rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      tag_q    <= '0;
      br_q     <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept && bus.in_md_en) begin
          state_q  <= S_RUN;
          cnt_q    <= SHW'(XLEN-1);
          op_q     <= bus.in_md_op;
          acc_q    <= {{XLEN{1'b0}}, a_mag};
          opnd_q   <= b_mag;
          dvd_q    <= bus.in_rs1;
          rs2_q    <= bus.in_rs2;
          imm_q    <= bus.in_imm;
          tag_q    <= bus.in_tag;
          br_q     <= br_taken;
          a_neg_q  <= a_neg;
          b_neg_q  <= b_neg;
          b_zero_q <= (bus.in_rs2 == '0);
        end
        S_RUN: begin
          acc_q <= acc_step;
          if (cnt_q == '0) state_q <= S_DONE;
          else             cnt_q   <= cnt_q - SHW'(1);
        end
        S_DONE: if (out_free) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mdu_idle   = (state_q == S_IDLE);
  assign busy       = !mdu_idle;
  assign alu_accept = accept && !bus.in_md_en;
  assign md_load    = (state_q == S_DONE) && out_free;
  assign md_rs2     = rs2_q;
  assign md_imm     = imm_q;
  assign md_tag     = tag_q;
  assign md_br      = br_q;
`else
  logic unused_md;
  assign unused_md  = ^{bus.in_md_en, bus.in_md_op};
  assign mdu_idle   = 1'b1;
  assign busy       = 1'b0;
  assign alu_accept = accept;
  assign md_load    = 1'b0;
  assign md_res     = '0;
  assign md_rs2     = '0;
  assign md_imm     = '0;
  assign md_tag     = '0;
  assign md_br      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rs2_q    <= '0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_br_q     <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (alu_accept) begin
      out_valid_q  <= 1'b1;
      out_result_q <= alu_res;
      out_rs2_q    <= bus.in_rs2;
      out_imm_q    <= bus.in_imm;
      out_tag_q    <= bus.in_tag;
      out_br_q     <= br_taken;
    end else if (md_load) begin
      out_valid_q  <= 1'b1;
      out_result_q <= md_res;
      out_rs2_q    <= md_rs2;
      out_imm_q    <= md_imm;
      out_tag_q    <= md_tag;
      out_br_q     <= md_br;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.out_result       = out_result_q;
  assign bus.out_rs2          = out_rs2_q;
  assign bus.out_imm          = out_imm_q;
  assign bus.out_tag          = out_tag_q;
  assign bus.out_branch_taken = out_br_q;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Self-checking bench for ex_stage_mdu: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_ex_stage_mdu;
  localparam int XLEN  = 32;
  localparam int TAG_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  ex_stage_mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  ex_stage_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        br;
    logic [15:0] tag;
  } out_t;

  int   tests = 0;
  int   fails = 0;
  bit   m_valid, m_pend;
  int   m_wait;
  out_t m_out, m_md;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return $signed(a) >>> sh;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic en, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic c;
    case (op)
      3'b000: c = (a == b);
      3'b001: c = (a != b);
      3'b100: c = ($signed(a) < $signed(b));
      3'b101: c = ($signed(a) >= $signed(b));
      3'b110: c = (a < b);
      3'b111: c = (a >= b);
      default: c = 1'b0;
    endcase
    return en && c;
  endfunction

  function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return 32'(sa / sb);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'd0; else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic bit exp_in_ready();
    return !flush && !m_pend && (!m_valid || bus.out_ready);
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_pend  = 0;
    m_wait  = 0;
    m_out   = '0;
    m_md    = '0;
  endtask

  // Advances the model across one rising edge using the inputs held during that cycle.
  task automatic model_update();
    bit   acc, fire, is_md;
    out_t o;
    acc   = bus.in_valid && exp_in_ready();
    fire  = m_valid && bus.out_ready;
    is_md = 0;
`ifdef EX_MDU_EN
    is_md = bus.in_md_en;
`endif
    if (flush) begin
      m_valid = 0;
      m_pend  = 0;
    end else if (m_pend) begin
      if (m_wait > 0) m_wait--;
      else if (!m_valid || bus.out_ready) begin
        m_out   = m_md;
        m_valid = 1;
        m_pend  = 0;
      end
    end else if (acc) begin
      o.rs2 = bus.in_rs2;
      o.imm = bus.in_imm;
      o.tag = bus.in_tag;
      o.br  = br_ref(bus.in_br_en, bus.in_br_op, bus.in_rs1, bus.in_rs2);
      if (is_md) begin
        o.result = mdu_ref(bus.in_md_op, bus.in_rs1, bus.in_rs2);
        m_md   = o;
        m_pend = 1;
        m_wait = XLEN;
        if (fire) m_valid = 0;
      end else begin
        o.result = alu_ref(bus.in_alu_op,
                           bus.in_src_a_sel ? bus.in_pc : bus.in_rs1,
                           bus.in_src_b_sel ? bus.in_imm : bus.in_rs2);
        m_out   = o;
        m_valid = 1;
      end
    end else if (fire) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("in_ready", bus.in_ready, exp_in_ready());
    check("busy", busy, m_pend);
    check("out_valid", bus.out_valid, m_valid);
    if (m_valid) begin
      check("out_result", bus.out_result, m_out.result);
      check("out_rs2", bus.out_rs2, m_out.rs2);
      check("out_imm", bus.out_imm, m_out.imm);
      check("out_branch_taken", bus.out_branch_taken, m_out.br);
      check("out_tag", bus.out_tag, m_out.tag);
    end
  endtask

  // Entered just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.in_valid     = 0;
    bus.in_alu_op    = '0;
    bus.in_src_a_sel = 0;
    bus.in_src_b_sel = 0;
    bus.in_br_en     = 0;
    bus.in_br_op     = '0;
    bus.in_md_en     = 0;
    bus.in_md_op     = '0;
    bus.in_rs1       = '0;
    bus.in_rs2       = '0;
    bus.in_pc        = '0;
    bus.in_imm       = '0;
    bus.in_tag       = '0;
    bus.out_ready    = 1;
    flush            = 0;
  endtask

  task automatic set_op(input logic [3:0] alu, input logic bsel, input logic br_en, input logic [2:0] br_op,
                        input logic md_en, input logic [2:0] md_op, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic [15:0] tag);
    bus.in_alu_op    = alu;
    bus.in_src_a_sel = 0;
    bus.in_src_b_sel = bsel;
    bus.in_br_en     = br_en;
    bus.in_br_op     = br_op;
    bus.in_md_en     = md_en;
    bus.in_md_op     = md_op;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_pc        = 32'h0000_1000;
    bus.in_imm       = imm;
    bus.in_tag       = tag;
  endtask

  task automatic drain();
    drive_idle();
    for (int i = 0; i < 60 && (m_pend || m_valid); i++) step();
  endtask

  // edges: rising edges after the accepting edge until the result shows; low: cycles in_ready was low.
  task automatic issue_wait(output logic [31:0] res, output int edges, output int low);
    bus.in_valid  = 1;
    bus.out_ready = 1;
    step();
    bus.in_valid = 0;
    edges = 0;
    low   = 0;
    while (!bus.out_valid && edges < 100) begin
      if (!bus.in_ready) low++;
      step();
      edges++;
    end
    check("result appears", bus.out_valid, 1);
    res = bus.out_result;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int edges, low, n;
    int exp_edges, exp_low;
`ifdef EX_MDU_EN
    exp_edges = XLEN + 1;
    exp_low   = XLEN + 1;
`else
    exp_edges = 0;
    exp_low   = 0;
`endif
    rst = 0;
    drive_idle();
    model_reset();
    #12;
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_result", bus.out_result, 0);
    check("reset out_tag", bus.out_tag, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1;

    set_op(4'd0, 0, 0, 3'd0, 0, 3'd0, 32'd5, 32'd7, 32'd0, 16'hA5A5);
    issue_wait(res, edges, low);
    check("ADD result", res, 32'd12);
    check("ADD latency", edges, 0);
    check("ADD tag", bus.out_tag, 16'hA5A5);

    drain();
    set_op(4'd0, 0, 1, 3'b110, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 16'h0001);
    issue_wait(res, edges, low);
    check("BLTU taken", bus.out_branch_taken, 0);
    drain();
    set_op(4'd0, 0, 1, 3'b100, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 16'h0002);
    issue_wait(res, edges, low);
    check("BLT taken", bus.out_branch_taken, 1);
    drain();
    set_op(4'd7, 1, 0, 3'd0, 0, 3'd0, 32'h8000_0000, 32'd0, 32'd31, 16'h0003);
    issue_wait(res, edges, low);
    check("SRA result", res, 32'hFFFF_FFFF);

    // M-extension cases; with the unit compiled out they run as ADD with latency 1.
    drain();
    set_op(4'd0, 0, 0, 3'd0, 1, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'd0, 16'h0004);
    issue_wait(res, edges, low);
`ifdef EX_MDU_EN
    check("MULH result", res, 32'h4000_0000);
`else
    check("MULH-as-ADD result", res, 32'h0000_0000);
`endif
    check("MULH edges", edges, exp_edges);
    check("MULH in_ready low", low, exp_low);

    drain();
    set_op(4'd0, 0, 0, 3'd0, 1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 16'h0005);
    issue_wait(res, edges, low);
`ifdef EX_MDU_EN
    check("DIV ovf", res, 32'h8000_0000);
`else
    check("DIV-as-ADD", res, 32'h7FFF_FFFF);
`endif
    drain();
    set_op(4'd0, 0, 0, 3'd0, 1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 16'h0006);
    issue_wait(res, edges, low);
`ifdef EX_MDU_EN
    check("REM ovf", res, 32'd0);
`else
    check("REM-as-ADD", res, 32'h7FFF_FFFF);
`endif
    drain();
    set_op(4'd0, 0, 0, 3'd0, 1, 3'b101, 32'd9, 32'd0, 32'd0, 16'h0007);
    issue_wait(res, edges, low);
`ifdef EX_MDU_EN
    check("DIVU by 0", res, 32'hFFFF_FFFF);
`else
    check("DIVU-as-ADD", res, 32'd9);
`endif
    drain();
    set_op(4'd0, 0, 0, 3'd0, 1, 3'b111, 32'd9, 32'd0, 32'd0, 16'h0008);
    issue_wait(res, edges, low);
    check("REMU by 0", res, 32'd9);

    // Result held under back-pressure, then released when out_ready rises.
    drain();
    set_op(4'd0, 0, 0, 3'd0, 1, 3'b101, 32'd100, 32'd7, 32'd0, 16'h0BB0);
    bus.in_valid = 1;
    step();
    bus.in_valid  = 0;
    bus.out_ready = 0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    check("bp result appears", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step();
`ifdef EX_MDU_EN
      check("bp hold result", bus.out_result, 32'd14);
`else
      check("bp hold result", bus.out_result, 32'd107);
`endif
      check("bp hold in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1;
    step();
    check("bp drained", bus.out_valid, 0);

    // Flush on the tenth cycle of a DIVU.
    drain();
    set_op(4'd0, 0, 0, 3'd0, 1, 3'b101, 32'd1000, 32'd3, 32'd0, 16'h0F0F);
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    repeat (9) step();
    flush = 1;
    step();
    flush = 0;
    check("flush busy", busy, 0);
    check("flush out_valid", bus.out_valid, 0);
    #1;
    check("flush in_ready", bus.in_ready, 1);
    repeat (40) step();

    // Asynchronous reset in the middle of a multiply.
    drain();
    set_op(4'd0, 0, 0, 3'd0, 1, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 16'h0C0C);
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    repeat (5) step();
    rst = 0;
    #1;
    check("mid-run reset out_valid", bus.out_valid, 0);
    check("mid-run reset busy", busy, 0);
    check("mid-run reset in_ready", bus.in_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1;
    repeat (40) step();

    for (int c = 0; c < 3000; c++) begin
      bus.in_valid     = ($urandom_range(0, 9) < 7);
      bus.in_alu_op    = 4'($urandom_range(0, 15));
      bus.in_src_a_sel = 1'($urandom_range(0, 1));
      bus.in_src_b_sel = 1'($urandom_range(0, 1));
      bus.in_br_en     = 1'($urandom_range(0, 1));
      bus.in_br_op     = 3'($urandom_range(0, 7));
      bus.in_md_en     = ($urandom_range(0, 9) < 3);
      bus.in_md_op     = 3'($urandom_range(0, 7));
      bus.in_rs1       = pick();
      bus.in_rs2       = pick();
      bus.in_pc        = $urandom;
      bus.in_imm       = pick();
      bus.in_tag       = 16'($urandom);
      bus.out_ready    = ($urandom_range(0, 9) < 7);
      flush            = ($urandom_range(0, 99) < 2);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
